// File: rtl/lfsr_checker.sv
// Serial PRBS checker for the 15-bit XNOR LFSR stream (feedback ~(s[14]^s[13]), shift-left,
// new bit into LSB). Self-synchronises in SEARCH, then free-runs a local copy in LOCKED.
// Optional feature macro: LFSR_CHK_LOSS_FLAG_EN adds the sticky sync_lost output.
module lfsr_checker #(
  parameter int unsigned LOCK_CNT   = 16,
  parameter int unsigned UNLOCK_CNT = 4,
  parameter int unsigned ERR_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             din,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_count,
  output logic [14:0]      state_out
`ifdef LFSR_CHK_LOSS_FLAG_EN
  ,
  output logic             sync_lost
`endif
);

  typedef enum logic {StSearch, StLocked} state_t;

  localparam logic [7:0] LockLim   = LOCK_CNT[7:0];
  localparam logic [7:0] UnlockLim = UNLOCK_CNT[7:0];

  state_t      state;
  logic [14:0] sh;
  logic [3:0]  fill;
  logic [7:0]  match;
  logic [7:0]  miss;

  logic exp_bit;
  logic hit;
  logic cnt_full;

  // Predicted next bit and search-mode hit qualification (all-ones lock-up never counts)
  always_comb begin
    exp_bit  = ~(sh[14] ^ sh[13]);
    hit      = (din == exp_bit) && (sh != 15'h7FFF);
    cnt_full = (err_count == {ERR_W{1'b1}});
  end

  assign locked    = (state == StLocked);
  assign state_out = sh;

  // Checker state machine, counters and registered err/err_count
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= StSearch;
      sh        <= '0;
      fill      <= '0;
      match     <= '0;
      miss      <= '0;
      err       <= 1'b0;
      err_count <= '0;
`ifdef LFSR_CHK_LOSS_FLAG_EN
      sync_lost <= 1'b0;
`endif
    end else begin
      err <= 1'b0;
      if (clr_cnt) begin
        err_count <= '0;
`ifdef LFSR_CHK_LOSS_FLAG_EN
        sync_lost <= 1'b0;
`endif
      end
      if (enable) begin
        unique case (state)
          StSearch: begin
            sh <= {sh[13:0], din};
            if (fill != 4'd15) begin
              fill <= fill + 4'd1;
            end else if (hit) begin
              if (match + 8'd1 == LockLim) begin
                state <= StLocked;
                match <= '0;
              end else begin
                match <= match + 8'd1;
              end
            end else begin
              match <= '0;
            end
          end
          StLocked: begin
            // Flywheel: the prediction, not the received bit, enters the register
            sh <= {sh[13:0], exp_bit};
            if (din != exp_bit) begin
              err <= 1'b1;
              if (clr_cnt) begin
                err_count <= {{(ERR_W-1){1'b0}}, 1'b1};
              end else if (!cnt_full) begin
                err_count <= err_count + 1'b1;
              end
              if (miss + 8'd1 == UnlockLim) begin
                state <= StSearch;
                fill  <= '0;
                match <= '0;
                miss  <= '0;
`ifdef LFSR_CHK_LOSS_FLAG_EN
                sync_lost <= 1'b1;
`endif
              end else begin
                miss <= miss + 8'd1;
              end
            end else begin
              miss <= '0;
            end
          end
          default: state <= StSearch;
        endcase
      end
    end
  end

endmodule
